// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory-access stage: bus widths, load/store opcodes,
// big-endian byte-lane select patterns and the bus transaction FSM encoding.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int AluOpBus   = 8;
  localparam int RegAddrBus = 5;

  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

  // Lane 0 is the most significant byte of the bus word.
  localparam logic [3:0] SEL_B0  = 4'b1000;
  localparam logic [3:0] SEL_B1  = 4'b0100;
  localparam logic [3:0] SEL_B2  = 4'b0010;
  localparam logic [3:0] SEL_B3  = 4'b0001;
  localparam logic [3:0] SEL_HHI = 4'b1100;
  localparam logic [3:0] SEL_HLO = 4'b0011;
  localparam logic [3:0] SEL_W   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: opcode decode, misalignment check, byte-lane
// selects, replicated store data and sign/zero-extended load extraction.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [RegBus-1:0]   reg2_i,
  input  logic [RegBus-1:0]   rdata_i,
  output logic                is_mem_o,
  output logic                is_store_o,
  output logic                is_load_o,
  output logic                misaligned_o,
  output logic [3:0]          sel_o,
  output logic [RegBus-1:0]   wdata_o,
  output logic [RegBus-1:0]   ldata_o
);

  logic [7:0]  byte_v;
  logic [3:0]  bsel;
  logic [15:0] half_v;
  logic [3:0]  hsel;

  always_comb begin
    byte_v = rdata_i[31:24];
    bsel   = SEL_B0;
    case (addr_lo_i)
      2'd0: begin byte_v = rdata_i[31:24]; bsel = SEL_B0; end
      2'd1: begin byte_v = rdata_i[23:16]; bsel = SEL_B1; end
      2'd2: begin byte_v = rdata_i[15:8];  bsel = SEL_B2; end
      default: begin byte_v = rdata_i[7:0]; bsel = SEL_B3; end
    endcase
    half_v = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    hsel   = addr_lo_i[1] ? SEL_HLO : SEL_HHI;
  end

  always_comb begin
    is_mem_o     = 1'b1;
    is_store_o   = 1'b0;
    misaligned_o = 1'b0;
    sel_o        = 4'b0000;
    wdata_o      = '0;
    ldata_o      = '0;
    case (aluop_i)
      EXE_LB_OP: begin
        sel_o   = bsel;
        ldata_o = {{24{byte_v[7]}}, byte_v};
      end
      EXE_LBU_OP: begin
        sel_o   = bsel;
        ldata_o = {24'b0, byte_v};
      end
      EXE_LH_OP: begin
        sel_o        = hsel;
        misaligned_o = addr_lo_i[0];
        ldata_o      = {{16{half_v[15]}}, half_v};
      end
      EXE_LHU_OP: begin
        sel_o        = hsel;
        misaligned_o = addr_lo_i[0];
        ldata_o      = {16'b0, half_v};
      end
      EXE_LW_OP: begin
        sel_o        = SEL_W;
        misaligned_o = |addr_lo_i;
        ldata_o      = rdata_i;
      end
      EXE_SB_OP: begin
        is_store_o = 1'b1;
        sel_o      = bsel;
        wdata_o    = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store_o   = 1'b1;
        sel_o        = hsel;
        misaligned_o = addr_lo_i[0];
        wdata_o      = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP: begin
        is_store_o   = 1'b1;
        sel_o        = SEL_W;
        misaligned_o = |addr_lo_i;
        wdata_o      = reg2_i;
      end
      default: is_mem_o = 1'b0;
    endcase
    is_load_o = is_mem_o & ~is_store_o;
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: single-outstanding strobe/ack data-bus transaction that
// stalls the pipeline until the access completes, then presents writeback data.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic                  cp0_reg_we_i,
  input  logic [4:0]            cp0_reg_write_addr_i,
  input  logic [RegBus-1:0]     cp0_reg_data_i,
  input  logic                  flush,
  input  logic [RegBus-1:0]     dbus_rdata,
  input  logic                  dbus_ack,
  output logic [RegBus-1:0]     dbus_addr,
  output logic [RegBus-1:0]     dbus_wdata,
  output logic [3:0]            dbus_sel,
  output logic                  dbus_we,
  output logic                  dbus_stb,
  output logic                  stallreq,
  output logic                  addr_err_o,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  cp0_reg_we_o,
  output logic [4:0]            cp0_reg_write_addr_o,
  output logic [RegBus-1:0]     cp0_reg_data_o
);

  lsu_state_e        state_q, state_d;
  logic [RegBus-1:0] rdata_q, rdata_d;

  logic              is_mem, is_store, is_load, misaligned;
  logic [3:0]        sel;
  logic [RegBus-1:0] st_wdata, ld_data;
  logic              req_ok, stb, stall;

  mem_lsu_align u_align (
    .aluop_i      (aluop_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .reg2_i       (reg2_i),
    .rdata_i      (rdata_q),
    .is_mem_o     (is_mem),
    .is_store_o   (is_store),
    .is_load_o    (is_load),
    .misaligned_o (misaligned),
    .sel_o        (sel),
    .wdata_o      (st_wdata),
    .ldata_o      (ld_data)
  );

  assign req_ok = is_mem & ~misaligned;

  // Flush overrides everything, including an ack in the same cycle.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    stb     = 1'b0;
    stall   = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_ok) begin
            stb   = 1'b1;
            stall = 1'b1;
            if (dbus_ack) begin
              rdata_d = dbus_rdata;
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          stb   = 1'b1;
          stall = 1'b1;
          if (dbus_ack) begin
            rdata_d = dbus_rdata;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    dbus_addr            = '0;
    dbus_wdata           = '0;
    dbus_sel             = 4'b0000;
    dbus_we              = 1'b0;
    dbus_stb             = 1'b0;
    stallreq             = 1'b0;
    addr_err_o           = 1'b0;
    wd_o                 = '0;
    wreg_o               = 1'b0;
    wdata_o              = '0;
    hi_o                 = '0;
    lo_o                 = '0;
    whilo_o              = 1'b0;
    cp0_reg_we_o         = 1'b0;
    cp0_reg_write_addr_o = '0;
    cp0_reg_data_o       = '0;
    if (!rst) begin
      dbus_stb = stb;
      stallreq = stall;
      if (stb) begin
        dbus_addr  = {mem_addr_i[31:2], 2'b00};
        dbus_wdata = st_wdata;
        dbus_sel   = sel;
        dbus_we    = is_store;
      end
      addr_err_o           = is_mem & misaligned;
      wd_o                 = wd_i;
      wreg_o               = wreg_i & ~(is_mem & misaligned) & ~flush;
      wdata_o              = is_load ? ld_data : wdata_i;
      hi_o                 = hi_i;
      lo_o                 = lo_i;
      whilo_o              = whilo_i & ~flush;
      cp0_reg_we_o         = cp0_reg_we_i & ~flush;
      cp0_reg_write_addr_o = cp0_reg_write_addr_i;
      cp0_reg_data_o       = cp0_reg_data_i;
    end
  end

endmodule
